instruction_fifo: RTL and testbench

Sits directly upstream of the look-ahead buffer. It assembles 80-bit instructions from three host word writes (lower/middle/upper), queues them in a circular FIFO, and presents them one at a time with a held-valid strobe. It honours the downstream stall (instr_busy) and enable. It also reports full, empty and overflow status to the host.

---
 rtl/instruction_fifo.sv | 138 +++++++++++++
 tb/tb_instruction_fifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fifo.sv
// Instruction FIFO: assembles 80-bit instructions from three host word writes,
// queues them in a circular buffer and presents them one at a time through a
// registered output slot with a held-valid strobe.
// Optional build macro: INSTR_FIFO_OCCUPANCY_EN adds occupancy/almost_full outputs.

package instruction_fifo_pkg;
  typedef logic [79:0] instr_type;
  localparam instr_type INIT_INSTR = '0;
endpackage

module instruction_fifo
  import instruction_fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 32,
  localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [31:0]       lower_word,
  input  logic              lower_write,
  input  logic [31:0]       middle_word,
  input  logic              middle_write,
  input  logic [15:0]       upper_word,
  input  logic              upper_write,
  input  logic              instr_busy,
  output instr_type         instr_out,
  output logic              instr_write,
  output logic              empty,
  output logic              full,
`ifdef INSTR_FIFO_OCCUPANCY_EN
  output logic [PTR_WIDTH:0] occupancy,
  output logic              almost_full,
`endif
  output logic              overflow
);

  localparam int unsigned CntW = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] CntFull = CntW'(FIFO_DEPTH);
`ifdef INSTR_FIFO_OCCUPANCY_EN
  localparam logic [PTR_WIDTH:0] CntAlmostFull = CntW'(FIFO_DEPTH - 2);
`endif

  instr_type              mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_WIDTH:0]     count_q, count_d;
  logic [31:0]            lower_q, middle_q;
  instr_type              instr_out_q;
  logic                   instr_write_q;
  logic                   empty_q, full_q, overflow_q;

  logic                   consume, pop, push_acc, ovf_hit;
  instr_type              entry;

  // Handshake decode, entry assembly with same-cycle bypass, and count update.
  always_comb begin
    consume  = instr_write_q && enable && !instr_busy;
    // Output side is frozen while disabled, so no pop either.
    pop      = enable && (count_q != '0) && (!instr_write_q || consume);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push_acc = upper_write && ((count_q != CntFull) || pop);
    ovf_hit  = upper_write && (count_q == CntFull) && !pop;
    entry    = {upper_word,
                middle_write ? middle_word : middle_q,
                lower_write  ? lower_word  : lower_q};
    count_d  = count_q;
    unique case ({push_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; not reset, only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      mem_q[wr_ptr_q] <= entry;
    end
  end

  // Pointers, count, staging regs, output slot and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      lower_q       <= '0;
      middle_q      <= '0;
      instr_out_q   <= INIT_INSTR;
      instr_write_q <= 1'b0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (lower_write)  lower_q  <= lower_word;
      if (middle_write) middle_q <= middle_word;
      if (push_acc)     wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q      <= rd_ptr_q + 1'b1;
        instr_out_q   <= mem_q[rd_ptr_q];
        instr_write_q <= 1'b1;
      end else if (consume) begin
        instr_out_q   <= INIT_INSTR;
        instr_write_q <= 1'b0;
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CntFull);
      if (ovf_hit) overflow_q <= 1'b1;
    end
  end

`ifdef INSTR_FIFO_OCCUPANCY_EN
  logic [PTR_WIDTH:0] occupancy_q;
  logic               almost_full_q;

  // Occupancy mirrors count; almost_full flags two or fewer free entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy_q   <= '0;
      almost_full_q <= 1'b0;
    end else begin
      occupancy_q   <= count_d;
      almost_full_q <= (count_d >= CntAlmostFull);
    end
  end

  assign occupancy   = occupancy_q;
  assign almost_full = almost_full_q;
`endif

  assign instr_out   = instr_out_q;
  assign instr_write = instr_write_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_instruction_fifo.sv
// Directed bench for instruction_fifo with a depth of 4.
module tb_instruction_fifo;
  import instruction_fifo_pkg::*;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst, enable, instr_busy;
  logic [31:0] lower_word, middle_word;
  logic [15:0] upper_word;
  logic        lower_write, middle_write, upper_write;
  instr_type   instr_out;
  logic        instr_write, empty, full, overflow;

  int tests = 0;
  int fails = 0;

  instruction_fifo #(.FIFO_DEPTH(Depth)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .lower_word   (lower_word),
    .lower_write  (lower_write),
    .middle_word  (middle_word),
    .middle_write (middle_write),
    .upper_word   (upper_word),
    .upper_write  (upper_write),
    .instr_busy   (instr_busy),
    .instr_out    (instr_out),
    .instr_write  (instr_write),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic instr_type mk(input logic [7:0] t);
    return {8'h08, t, 24'h000002, t, 24'h000001, t};
  endfunction

  task automatic push_all(input instr_type v);
    lower_word   = v[31:0];
    middle_word  = v[63:32];
    upper_word   = v[79:64];
    lower_write  = 1'b1;
    middle_write = 1'b1;
    upper_write  = 1'b1;
  endtask

  task automatic no_writes();
    lower_write  = 1'b0;
    middle_write = 1'b0;
    upper_write  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; instr_busy = 1'b0;
    lower_word = '0; middle_word = '0; upper_word = '0;
    no_writes();
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();

    // Reset state
    check("rst_write", instr_write, 0);
    check("rst_out", instr_out, INIT_INSTR);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);

    // Single instruction assembled from three separate writes
    lower_word = 32'h0000_0010; lower_write = 1'b1; tick();
    lower_write = 1'b0; middle_word = 32'h0000_0004; middle_write = 1'b1; tick();
    middle_write = 1'b0; upper_word = 16'h0800; upper_write = 1'b1; tick();
    upper_write = 1'b0;
    check("single_not_yet", instr_write, 0);
    tick();
    check("single_write", instr_write, 1);
    check("single_out", instr_out, 80'h0800_00000004_00000010);
    check("single_empty", empty, 1);
    tick();
    check("single_done", instr_write, 0);
    check("single_out_init", instr_out, INIT_INSTR);
    check("single_empty2", empty, 1);

    // Fill to full, then push and consume in the same cycle
    instr_busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push_all(mk(8'(8'h20 + i)));
      tick();
    end
    check("fill_full", full, 1);
    check("fill_ovf", overflow, 0);
    check("fill_out", instr_out, mk(8'h21));
    instr_busy = 1'b0;
    push_all(mk(8'h26));
    tick();
    no_writes();
    check("pp_full", full, 1);
    check("pp_empty", empty, 0);
    check("pp_ovf", overflow, 0);
    check("pp_out", instr_out, mk(8'h22));
    for (int k = 2; k <= 6; k++) begin
      check("pp_order", instr_out, mk(8'(8'h20 + k)));
      check("pp_valid", instr_write, 1);
      tick();
    end
    check("pp_drained", instr_write, 0);
    check("pp_drained_empty", empty, 1);

    // Push six while stalled: one in the slot, four stored, sixth overflows
    instr_busy = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      push_all(mk(8'(8'h10 + i)));
      tick();
      if (i == 5) begin
        check("ovf_full5", full, 1);
        check("ovf_not_yet", overflow, 0);
      end
    end
    no_writes();
    check("ovf_set", overflow, 1);
    check("ovf_full", full, 1);
    check("ovf_slot", instr_out, mk(8'h11));
    check("ovf_slot_valid", instr_write, 1);
    instr_busy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check("deliver_order", instr_out, mk(8'(8'h10 + k)));
      check("deliver_valid", instr_write, 1);
      if (k == 2) begin
        // Stall three cycles: output must hold
        instr_busy = 1'b1;
        repeat (3) begin
          tick();
          check("stall_hold", instr_out, mk(8'h12));
          check("stall_valid", instr_write, 1);
        end
        instr_busy = 1'b0;
      end
      tick();
    end
    check("deliver_done", instr_write, 0);
    check("deliver_empty", empty, 1);
    check("ovf_sticky", overflow, 1);

    // Reset with three queued entries and a valid slot
    instr_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push_all(mk(8'(8'h30 + i)));
      tick();
    end
    no_writes();
    check("prerst_valid", instr_write, 1);
    check("prerst_empty", empty, 0);
    rst = 1'b1;
    lower_word = 32'hDEAD_BEEF; lower_write = 1'b1;
    tick();
    rst = 1'b0; lower_write = 1'b0; instr_busy = 1'b0;
    check("rst2_write", instr_write, 0);
    check("rst2_empty", empty, 1);
    check("rst2_full", full, 0);
    check("rst2_ovf", overflow, 0);
    check("rst2_out", instr_out, INIT_INSTR);
    upper_word = 16'hABCD; upper_write = 1'b1;
    tick();
    upper_write = 1'b0;
    tick();
    check("post_rst_valid", instr_write, 1);
    check("post_rst_out", instr_out, {16'hABCD, 32'h0, 32'h0});
    tick();
    check("post_rst_done", instr_write, 0);
    check("post_rst_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
